id_ex_operand_stage: RTL

- Pipeline register between decode/register-file read and execute in the RISC-V core.
- Captures rs1/rs2 values read from the register file in the same cycle.
- Forwards newer results from the MEM and WB stages. The regfile writes on the clock edge and reads combinationally, so same-cycle WB data must be bypassed.
- Detects load-use hazards and inserts bubbles. Keeps a saturating stall counter for performance monitoring.

---
 rtl/id_ex_operand_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use hazard
// detection with bubble insertion, and a saturating hazard-stall counter.
module id_ex_operand_stage #(
   parameter int W  = 31,
   parameter int CW = 31
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          flush,
   // decode side
   input  logic          id_valid,
   output logic          id_ready,
   input  logic [4:0]    id_radd1,
   input  logic [4:0]    id_radd2,
   input  logic [W:0]    id_rs1_val,
   input  logic [W:0]    id_rs2_val,
   input  logic          id_use_rs1,
   input  logic          id_use_rs2,
   input  logic [4:0]    id_rd,
   input  logic          id_rd_wen,
   input  logic          id_is_load,
   input  logic [W:0]    id_pc,
   // MEM stage
   input  logic [4:0]    mem_rd,
   input  logic          mem_rd_wen,
   input  logic          mem_is_load,
   input  logic [W:0]    mem_data,
   // WB stage (same port as the regfile write)
   input  logic          wb_wen,
   input  logic [4:0]    wb_add,
   input  logic [W:0]    wb_data,
   // execute side
   input  logic          ex_ready,
   output logic          ex_valid,
   output logic [W:0]    ex_op1,
   output logic [W:0]    ex_op2,
   output logic [4:0]    ex_rd,
   output logic          ex_rd_wen,
   output logic          ex_is_load,
   output logic [W:0]    ex_pc,
   output logic [CW:0]   stall_cnt
);

   // x0 is hardwired to zero, so it never forwards and never stalls.
   function automatic logic src_match(input logic       use_src,
                                      input logic [4:0] radd,
                                      input logic       wen,
                                      input logic [4:0] rd);
      return use_src && (radd != 5'd0) && wen && (radd == rd);
   endfunction

   logic          rs1_mem_match, rs2_mem_match;
   logic          rs1_wb_match,  rs2_wb_match;
   logic          rs1_ex_match,  rs2_ex_match;
   logic          ex_load_pending;
   logic          hazard;
   logic          advance;
   logic          accept;
   logic [W:0]    fwd_op1, fwd_op2;

   assign rs1_mem_match = src_match(id_use_rs1, id_radd1, mem_rd_wen, mem_rd);
   assign rs2_mem_match = src_match(id_use_rs2, id_radd2, mem_rd_wen, mem_rd);
   assign rs1_wb_match  = src_match(id_use_rs1, id_radd1, wb_wen, wb_add);
   assign rs2_wb_match  = src_match(id_use_rs2, id_radd2, wb_wen, wb_add);

   // A load in our own output register has no data until it leaves MEM.
   assign ex_load_pending = ex_valid && ex_is_load && ex_rd_wen;
   assign rs1_ex_match    = src_match(id_use_rs1, id_radd1, ex_load_pending, ex_rd);
   assign rs2_ex_match    = src_match(id_use_rs2, id_radd2, ex_load_pending, ex_rd);

   assign hazard = id_valid &&
                   (rs1_ex_match || rs2_ex_match ||
                    (mem_is_load && (rs1_mem_match || rs2_mem_match)));

   assign advance  = ex_ready || !ex_valid;
   assign id_ready = advance && !hazard && !flush;
   assign accept   = id_valid && id_ready;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      fwd_op1 = id_rs1_val;
      fwd_op2 = id_rs2_val;
      if (rs1_mem_match && !mem_is_load) fwd_op1 = mem_data;
      else if (rs1_wb_match)             fwd_op1 = wb_data;
      if (rs2_mem_match && !mem_is_load) fwd_op2 = mem_data;
      else if (rs2_wb_match)             fwd_op2 = wb_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ex_valid   <= 1'b0;
         ex_op1     <= '0;
         ex_op2     <= '0;
         ex_rd      <= '0;
         ex_rd_wen  <= 1'b0;
         ex_is_load <= 1'b0;
         ex_pc      <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid   <= 1'b1;
         ex_op1     <= fwd_op1;
         ex_op2     <= fwd_op2;
         ex_rd      <= id_rd;
         ex_rd_wen  <= id_rd_wen;
         ex_is_load <= id_is_load;
         ex_pc      <= id_pc;
      end else if (advance) begin
         ex_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         stall_cnt <= '0;
      else if (hazard && !flush && (stall_cnt != '1))
         stall_cnt <= stall_cnt + {{CW{1'b0}}, 1'b1};
   end

endmodule
